// File: rtl/hex_ascii_pkg.sv
// rtl/hex_ascii_pkg.sv - ASCII constants, encoder offsets and parser state type
package hex_ascii_pkg;

  localparam logic [6:0] ASCII_0     = 7'h30;
  localparam logic [6:0] ASCII_9     = 7'h39;
  localparam logic [6:0] ASCII_UA    = 7'h41;
  localparam logic [6:0] ASCII_UF    = 7'h46;
  localparam logic [6:0] ASCII_LA    = 7'h61;
  localparam logic [6:0] ASCII_LOWF  = 7'h66;
  localparam logic [6:0] ASCII_SPACE = 7'h20;
  localparam logic [6:0] ASCII_LF    = 7'h0A;
  localparam logic [6:0] ASCII_CR    = 7'h0D;
  localparam logic [6:0] ASCII_COMMA = 7'h2C;

  // Offsets shared with the hex-to-ASCII encoders: char = nibble + offset.
  localparam logic [6:0] OFS_NUM   = 7'h30;
  localparam logic [6:0] OFS_UPPER = 7'h37;
  localparam logic [6:0] OFS_LOWER = 7'h57;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ACCUM,
    ST_OUT,
    ST_ERR,
    ST_SKIP
  } parser_state_t;

  function automatic logic is_delim_char(input logic [6:0] c);
    return (c == ASCII_SPACE) || (c == ASCII_LF) || (c == ASCII_CR) || (c == ASCII_COMMA);
  endfunction

endpackage

// File: rtl/ascii2nibble.sv
// rtl/ascii2nibble.sv - combinational ASCII hex character classifier and nibble decoder
module ascii2nibble
  import hex_ascii_pkg::*;
(
  input  logic [6:0] in_char,
  output logic [3:0] nib,
  output logic       is_digit,
  output logic       is_delim
);

  logic w_num;
  logic w_upper;
  logic w_lower;

  assign w_num   = (in_char >= ASCII_0)  && (in_char <= ASCII_9);
  assign w_upper = (in_char >= ASCII_UA) && (in_char <= ASCII_UF);
  assign w_lower = (in_char >= ASCII_LA) && (in_char <= ASCII_LOWF);

  always_comb begin
    nib = 4'h0;
    if (w_num) begin
      nib = 4'(in_char - OFS_NUM);
    end else if (w_upper) begin
      nib = 4'(in_char - OFS_UPPER);
    end else if (w_lower) begin
      nib = 4'(in_char - OFS_LOWER);
    end
  end

  assign is_digit = w_num || w_upper || w_lower;
  assign is_delim = is_delim_char(in_char);

endmodule

// File: rtl/ascii_hex_parser.sv
// rtl/ascii_hex_parser.sv - streaming ASCII hex to binary word parser with error words
module ascii_hex_parser
  import hex_ascii_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [6:0]            in_char,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [4*DIGITS-1:0]   out_word,
  output logic                  out_err
);

  localparam int W  = 4 * DIGITS;
  localparam int CW = $clog2(DIGITS + 1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DIGITS);

  parser_state_t r_state;
  parser_state_t w_state_nxt;
  logic [W-1:0]  r_acc;
  logic [W-1:0]  w_acc_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic [CW-1:0] w_cnt_inc;
  logic [3:0]    w_nib;
  logic          w_is_digit;
  logic          w_is_delim;
  logic          w_in_fire;
  logic          w_out_fire;

  ascii2nibble u_ascii2nibble (
    .in_char  (in_char),
    .nib      (w_nib),
    .is_digit (w_is_digit),
    .is_delim (w_is_delim)
  );

  // Handshake outputs decode straight from the state register.
  assign in_ready  = (r_state == ST_IDLE) || (r_state == ST_ACCUM) || (r_state == ST_SKIP);
  assign out_valid = (r_state == ST_OUT) || (r_state == ST_ERR);
  assign out_err   = (r_state == ST_ERR);
  assign out_word  = (r_state == ST_OUT) ? r_acc : '0;

  assign w_in_fire  = in_valid && in_ready;
  assign w_out_fire = out_valid && out_ready;
  assign w_cnt_inc  = r_cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_in_fire) begin
          if (w_is_digit) begin
            w_acc_nxt   = W'(w_nib);
            w_cnt_nxt   = CW'(1);
            w_state_nxt = (DIGITS == 1) ? ST_OUT : ST_ACCUM;
          end else if (!w_is_delim) begin
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_ACCUM: begin
        if (w_in_fire) begin
          if (w_is_digit) begin
            w_acc_nxt = (r_acc << 4) | W'(w_nib);
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == CNT_FULL) begin
              w_state_nxt = ST_OUT;
            end
          end else if (w_is_delim) begin
            w_state_nxt = ST_OUT;
          end else begin
            w_acc_nxt   = '0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_ERR;
          end
        end
      end
      ST_OUT: begin
        if (w_out_fire) begin
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ERR: begin
        if (w_out_fire) begin
          w_state_nxt = ST_SKIP;
        end
      end
      // Drop the rest of a bad token; only a delimiter resynchronises.
      ST_SKIP: begin
        if (w_in_fire && w_is_delim) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_acc_nxt   = '0;
        w_cnt_nxt   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_ascii_hex_parser.sv
// tb/tb_ascii_hex_parser.sv - self-checking bench for ascii_hex_parser
module tb_ascii_hex_parser;

  localparam int DIGITS = 4;
  localparam int W      = 4 * DIGITS;

  logic         clk       = 1'b0;
  logic         rst       = 1'b1;
  logic         in_valid  = 1'b0;
  logic [6:0]   in_char   = 7'h00;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic         out_err;
  logic [W-1:0] out_word;

  ascii_hex_parser #(.DIGITS(DIGITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_char   (in_char),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_word  (out_word),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  logic [W:0] got_q[$];
  logic [W:0] exp_q[$];
  bit rand_rdy = 1'b0;
  logic [6:0] delims [4] = '{7'h20, 7'h0A, 7'h0D, 7'h2C};

  typedef struct {
    string       stim;
    int          n;
    logic [63:0] words;
    logic [3:0]  errs;
  } vec_t;
  vec_t vecs[$];

  bit          m_skip = 1'b0;
  int unsigned m_nibs[$];

  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) got_q.push_back({out_err, out_word});
  end

  always @(posedge clk) begin
    if (rand_rdy) begin
      #1;
      out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic logic [6:0] hex2ascii_bh(input logic [3:0] n);
    return (n < 4'd10) ? 7'h30 + 7'(n) : 7'h37 + 7'(n);
  endfunction

  function automatic int hex_val(input logic [6:0] c);
    if (c >= 7'h30 && c <= 7'h39) return int'(c) - 48;
    if (c >= 7'h41 && c <= 7'h46) return int'(c) - 55;
    if (c >= 7'h61 && c <= 7'h66) return int'(c) - 87;
    return -1;
  endfunction

  function automatic bit is_delim_c(input logic [6:0] c);
    foreach (delims[k]) if (c == delims[k]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic void model_reset();
    m_skip = 1'b0;
    m_nibs.delete();
  endfunction

  function automatic void model_emit();
    int unsigned v = 0;
    foreach (m_nibs[k]) v = v * 16 + m_nibs[k];
    exp_q.push_back({1'b0, W'(v)});
    m_nibs.delete();
  endfunction

  // Token-level view: collect digits until full or delimited; a bad char poisons the token.
  function automatic void model_char(input logic [6:0] c);
    int d = hex_val(c);
    if (m_skip) begin
      if (is_delim_c(c)) m_skip = 1'b0;
    end else if (d >= 0) begin
      m_nibs.push_back(d);
      if (m_nibs.size() == DIGITS) model_emit();
    end else if (is_delim_c(c)) begin
      if (m_nibs.size() > 0) model_emit();
    end else begin
      m_nibs.delete();
      exp_q.push_back({1'b1, W'(0)});
      m_skip = 1'b1;
    end
  endfunction

  task automatic send_char(input logic [6:0] c);
    int waited = 0;
    in_valid = 1'b1;
    in_char  = c;
    while (!in_ready && waited < 64) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      n_checks++;
      $display("FAIL in_ready_wait: in_ready=%b after %0d cycles, required 1", in_ready, waited);
      in_valid = 1'b0;
      return;
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_char(7'(s[i]));
  endtask

  task automatic compare_queues(input string name);
    check({name, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
      check($sformatf("%s[%0d]", name, k), 32'(got_q[k]), 32'(exp_q[k]));
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    logic [6:0] c;
    int r;

    vecs.push_back('{"1A2f",     1, {16'h1A2F, 48'h0},            4'b0000});
    vecs.push_back('{"7B\n",     1, {16'h007B, 48'h0},            4'b0000});
    vecs.push_back('{" \r",      0, 64'h0,                        4'b0000});
    vecs.push_back('{"12G4 56 ", 2, {16'h0000, 16'h0056, 32'h0},  4'b1000});
    vecs.push_back('{"1234 ",    1, {16'h1234, 48'h0},            4'b0000});
    vecs.push_back('{"x,5,",     2, {16'h0000, 16'h0005, 32'h0},  4'b1000});
    vecs.push_back('{"FFFF0000", 2, {16'hFFFF, 16'h0000, 32'h0},  4'b0000});
    vecs.push_back('{"#!\n9,",   2, {16'h0000, 16'h0009, 32'h0},  4'b1000});

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_out_err",   32'(out_err),   32'd0);
    check("reset_out_word",  32'(out_word),  32'd0);
    check("reset_in_ready",  32'(in_ready),  32'd1);

    foreach (vecs[v]) begin
      send_str(vecs[v].stim);
      repeat (4) @(negedge clk);
      for (int k = 0; k < vecs[v].n; k++)
        exp_q.push_back({vecs[v].errs[3-k], vecs[v].words[63-16*k -: 16]});
      compare_queues($sformatf("vec%0d", v));
    end

    // Output appears the cycle after the completing character is accepted.
    send_str("1A2");
    check("lat_pre_valid", 32'(out_valid), 32'd0);
    send_char(7'h66);
    check("lat_valid", 32'(out_valid), 32'd1);
    check("lat_word",  32'(out_word),  32'h1A2F);
    repeat (3) @(negedge clk);
    exp_q.push_back({1'b0, 16'h1A2F});
    compare_queues("latency");

    send_char(7'h20);
    check("delim_idle_ready0", 32'(in_ready), 32'd1);
    send_char(7'h0D);
    check("delim_idle_ready1", 32'(in_ready), 32'd1);
    check("delim_idle_valid",  32'(out_valid), 32'd0);

    for (int d = 0; d < 16; d++) begin
      for (int lc = 0; lc < 2; lc++) begin
        c = hex2ascii_bh(d[3:0]);
        if (lc == 1 && d > 9) c = c + 7'h20;
        send_char(c);
        send_char(7'h20);
        exp_q.push_back({1'b0, W'(d)});
      end
    end
    repeat (4) @(negedge clk);
    compare_queues("digits");

    // Backpressure holds the word and stalls input.
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    send_str("ABCD");
    check("bp_valid",    32'(out_valid), 32'd1);
    check("bp_in_ready", 32'(in_ready),  32'd0);
    check("bp_word",     32'(out_word),  32'hABCD);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check($sformatf("bp_hold_word%0d", i),  32'(out_word), 32'hABCD);
      check($sformatf("bp_hold_err%0d", i),   32'(out_err),  32'd0);
      check($sformatf("bp_hold_ready%0d", i), 32'(in_ready), 32'd0);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("bp_after_ready", 32'(in_ready),  32'd1);
    check("bp_after_valid", 32'(out_valid), 32'd0);
    exp_q.push_back({1'b0, 16'hABCD});
    compare_queues("backpressure");

    send_str("9E");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_mid_valid", 32'(out_valid), 32'd0);
    check("rst_mid_ready", 32'(in_ready),  32'd1);
    send_str("3 ");
    repeat (4) @(negedge clk);
    exp_q.push_back({1'b0, 16'h0003});
    compare_queues("rst_mid_word");

    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    send_str("ABCD");
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 begin rst = 1'b0; out_ready = 1'b1; end
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    send_str("5,");
    repeat (4) @(negedge clk);
    exp_q.push_back({1'b0, 16'h0005});
    compare_queues("rst_out_word");

    model_reset();
    rand_rdy = 1'b1;
    for (int i = 0; i < 400; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 60) begin
        c = hex2ascii_bh(4'($urandom_range(0, 15)));
        if (c > 7'h39 && $urandom_range(0, 1) == 1) c = c + 7'h20;
      end else if (r < 85) begin
        c = delims[$urandom_range(0, 3)];
      end else begin
        do c = 7'($urandom_range(0, 127)); while (hex_val(c) >= 0 || is_delim_c(c));
      end
      model_char(c);
      send_char(c);
      if ($urandom_range(0, 3) == 0) @(negedge clk);
    end
    model_char(7'h20);
    send_char(7'h20);
    rand_rdy = 1'b0;
    @(posedge clk);
    #1 out_ready = 1'b1;
    repeat (10) @(negedge clk);
    compare_queues("random");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/ascii_hex_parser.md
Name: ascii_hex_parser

Overview:
Streaming decoder that turns a stream of 7-bit ASCII hex characters back into binary words, the inverse of our hex-to-ASCII encoders. It accepts one character per handshake, accumulates up to DIGITS hex digits MSB-first, and emits a word on a valid/ready output. Delimiters terminate a word early; illegal characters produce a flagged error word. It sits between a character source (UART RX / console FIFO) and a word consumer.

Parameters:
DIGITS, 4, maximum hex digits per word; output width is 4*DIGITS.

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  in_char is valid
in_ready  output  1  parser accepts in_char this cycle
in_char  input  7  ASCII character
out_valid  output  1  out_word/out_err are valid
out_ready  input  1  consumer accepts the output
out_word  output  4*DIGITS  decoded value, right-aligned, zero-extended
out_err  output  1  the emitted word is an error marker

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. Input transfer occurs when in_valid && in_ready; output transfer occurs when out_valid && out_ready.
- Character classes:
  - DIGIT: 0x30-0x39 -> c-0x30; 0x41-0x46 -> c-0x37; 0x61-0x66 -> c-0x57.
  - DELIM: 0x20 space, 0x0A LF, 0x0D CR, 0x2C comma.
  - ILLEGAL: everything else.
- State machine: IDLE, ACCUM, OUT, ERR, SKIP. in_ready=1 in IDLE/ACCUM/SKIP and 0 in OUT/ERR. out_valid=1 only in OUT/ERR.
- IDLE:
  - DIGIT: acc={0..,nib}, cnt=1, go to ACCUM (or OUT if DIGITS==1).
  - DELIM: ignored, stay in IDLE.
  - ILLEGAL: go to ERR.
- ACCUM:
  - DIGIT: acc=(acc<<4)|nib, cnt++. When cnt reaches DIGITS, go to OUT.
  - DELIM: go to OUT with the partial acc, right-aligned.
  - ILLEGAL: go to ERR, discarding acc.
- OUT: out_word=acc, out_err=0, held stable until out_ready. On transfer: acc=0, cnt=0, go to IDLE.
- ERR: out_word=0, out_err=1, held until out_ready. On transfer go to SKIP.
- SKIP: all characters are consumed and dropped. DELIM returns to IDLE; ILLEGAL stays in SKIP.
- Full-width words: a delimiter following a full-width word arrives in IDLE and is ignored, so "1234 " yields one word.
- Latency: the character accepted in cycle N that completes or terminates a word gives out_valid=1 in cycle N+1 (registered outputs). The earliest next input accept is the cycle after the output transfer.
- Reset:
  - Values: state=IDLE, acc=0, cnt=0, out_valid=0, out_err=0, out_word=0, in_ready=1 (combinational from state).
  - Reset mid-word or mid-output discards everything; no word is emitted.
- Output stability: out_word and out_err do not change while out_valid=1 && out_ready=0. in_char is ignored when in_valid=0.
- Width rules: cnt is $clog2(DIGITS+1) bits. The shift never overflows because the word is forced out at cnt==DIGITS.

Decomposition:
- Package hex_ascii_pkg:
  - ASCII constants: ASCII_0=7'h30, ASCII_UA=7'h41, ASCII_LA=7'h61, SPACE, LF, CR, COMMA.
  - Offsets 7'h30/7'h37/7'h57, shared with the encoders.
  - State enum.
- Sub-module ascii2nibble (combinational): in_char[6:0] -> nib[3:0], is_digit, is_delim. This is the exact inverse of the existing hex-to-ASCII encoders.
- The parser holds only the FSM, accumulator and counter.

Test Plan:
- Reset, then "1A2f" with out_ready=1, DIGITS=4 -> single word 16'h1A2F, out_err=0, out_valid one cycle after the 'f' accept.
- "7B\n" -> word 16'h007B, out_err=0. A following " \r" emits nothing and in_ready stays 1.
- "12G4 56 " -> error word (out_word=0, out_err=1); '4' is dropped in SKIP, then word 16'h0056.
- "ABCD" with out_ready held 0 for 5 cycles -> out_valid=1 and out_word=16'hABCD stable, in_ready=0 throughout; transfer on out_ready=1, in_ready=1 the next cycle.
- All 16 digits 0-F (upper and lowercase), single-digit words separated by spaces -> words 0x0000..0x000F. Each must match the round-trip through hex2ascii_bh for the uppercase set.
- Assert rst after "9E" accepted -> no output; the next "3 " yields 16'h0003.
